// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter state type, largest legal digit and a digit validity check.
// Also meant for the decade counters and the binary-to-BCD block.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd_digit(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter: one digit per clock, most significant first,
// acc = acc*10 + digit, with valid/ready handshakes on both sides and one word in flight.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // True when 2^w can hold the largest d-digit decimal value (10^d - 1).
    function automatic bit width_ok(input int d, input int w);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        if (w >= 64) begin
            return 1'b1;
        end
        return ((64'd1 << w) >= p);
    endfunction

    if (DIGITS < 1 || !width_ok(DIGITS, BIN_W)) begin : g_param_check
        $error("bcd_to_bin_seq: DIGITS must be >= 1 and 2^BIN_W must exceed 10^DIGITS - 1");
    end

    bcd_state_t             r_state;
    bcd_state_t             w_state_nxt;
    logic [4*DIGITS-1:0]    r_word;
    logic [BIN_W-1:0]       r_acc;
    logic [BIN_W-1:0]       r_bin;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_err;
    logic                   r_out_valid;

    logic [3:0]             w_digit;
    logic [BIN_W-1:0]       w_acc_x10;
    logic [BIN_W-1:0]       w_acc_nxt;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_release;

    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit = r_word[4*k +: 4];
            end
        end
    end

    // x10 as shift-add, truncated to BIN_W; raw non-BCD digits are still added.
    assign w_acc_x10 = (r_acc << 3) + (r_acc << 1);
    assign w_acc_nxt = w_acc_x10 + BIN_W'(w_digit);
    assign w_last    = (r_idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = CONV;
                    w_accept    = 1'b1;
                end
            end
            CONV: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word      <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_bin       <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_word <= bcd_in;
            r_acc  <= '0;
            r_idx  <= IDX_LAST;
            r_err  <= 1'b0;
        end else if (r_state == CONV) begin
            r_acc <= w_acc_nxt;
            r_idx <= r_idx - IDX_W'(1);
            if (!is_bcd_digit(w_digit)) begin
                r_err <= 1'b1;
            end
            if (w_last) begin
                r_bin       <= w_acc_nxt;
                r_out_valid <= 1'b1;
            end
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin;
    assign err       = r_err;

endmodule
